// File: rtl/piano_pkg.sv
// ============================================================================
// Module   : piano_pkg
// Brief    : Note/octave codes, mid-octave pitch table and the half-period
//            helper shared by the audio blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package piano_pkg;

  localparam int unsigned c_CNT_W_DEFAULT = 20;

  typedef enum logic [3:0] {
    NOTE_REST = 4'd0,
    NOTE_DO   = 4'd1,
    NOTE_RE   = 4'd2,
    NOTE_MI   = 4'd3,
    NOTE_FA   = 4'd4,
    NOTE_SOL  = 4'd5,
    NOTE_LA   = 4'd6,
    NOTE_SI   = 4'd7
  } note_e;

  typedef enum logic [1:0] {
    OCT_MID     = 2'b00,
    OCT_HIGH    = 2'b01,
    OCT_LOW     = 2'b10,
    OCT_MID_ALT = 2'b11
  } octave_e;

  // Mid-octave pitches in centi-hertz
  localparam int unsigned c_FCHZ_DO  = 26163;
  localparam int unsigned c_FCHZ_RE  = 29366;
  localparam int unsigned c_FCHZ_MI  = 32963;
  localparam int unsigned c_FCHZ_FA  = 34923;
  localparam int unsigned c_FCHZ_SOL = 39200;
  localparam int unsigned c_FCHZ_LA  = 44000;
  localparam int unsigned c_FCHZ_SI  = 49388;

  // Clock cycles per half period: clk_hz / (2 * f_Hz) = clk_hz * 50 / f_cHz
  function automatic int unsigned half_period(input longint unsigned clk_hz,
                                              input int unsigned     f_chz);
    longint unsigned q;
    if (f_chz == 0) begin
      q = 64'd0;
    end else begin
      q = (clk_hz * 64'd50) / 64'(f_chz);
    end
    return q[31:0];
  endfunction

  function automatic logic note_is_valid(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_period_lut.sv
// ============================================================================
// Module   : note_period_lut
// Brief    : Combinational (note, octave) -> half-period count; 0 for rests.
// Revision : 1.0
// ============================================================================
`default_nettype none

module note_period_lut
  import piano_pkg::*;
#(
  parameter longint unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned     CNT_W       = c_CNT_W_DEFAULT
) (
  input  logic [3:0]       i_note,
  input  logic [1:0]       i_octave,
  output logic [CNT_W-1:0] o_period
);

  localparam logic [CNT_W-1:0] c_MID_DO  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_DO));
  localparam logic [CNT_W-1:0] c_MID_RE  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_RE));
  localparam logic [CNT_W-1:0] c_MID_MI  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_MI));
  localparam logic [CNT_W-1:0] c_MID_FA  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_FA));
  localparam logic [CNT_W-1:0] c_MID_SOL = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_SOL));
  localparam logic [CNT_W-1:0] c_MID_LA  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_LA));
  localparam logic [CNT_W-1:0] c_MID_SI  = CNT_W'(half_period(CLK_FREQ_HZ, c_FCHZ_SI));

  logic [CNT_W-1:0] w_mid;

  always_comb begin
    w_mid = '0;
    case (i_note)
      NOTE_DO:  w_mid = c_MID_DO;
      NOTE_RE:  w_mid = c_MID_RE;
      NOTE_MI:  w_mid = c_MID_MI;
      NOTE_FA:  w_mid = c_MID_FA;
      NOTE_SOL: w_mid = c_MID_SOL;
      NOTE_LA:  w_mid = c_MID_LA;
      NOTE_SI:  w_mid = c_MID_SI;
      default:  w_mid = '0;
    endcase
  end

  always_comb begin
    o_period = w_mid;
    case (i_octave)
      OCT_HIGH: o_period = w_mid >> 1;
      OCT_LOW:  o_period = w_mid << 1;
      default:  o_period = w_mid;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/buzzer_tone_gen.sv
// ============================================================================
// Module   : buzzer_tone_gen
// Brief    : Glitch-free square-wave buzzer driver; pitch and note-off change
//            only at half-period boundaries. TONE_VOLUME_EN adds PWM gating.
// Revision : 1.0
// ============================================================================
`default_nettype none

module buzzer_tone_gen
  import piano_pkg::*;
#(
  parameter longint unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned     CNT_W       = c_CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
`ifdef TONE_VOLUME_EN
  input  logic [1:0] volume,
`endif
  output logic       speaker_out,
  output logic       playing
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_note_q;
  logic [1:0]       r_oct_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_tone;
  logic [CNT_W-1:0] w_lut_period;
  logic             w_note_valid;
  logic             w_boundary;

  note_period_lut #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .CNT_W      (CNT_W)
  ) u_lut (
    .i_note  (r_note_q),
    .i_octave(r_oct_q),
    .o_period(w_lut_period)
  );

  assign w_note_valid = note_is_valid(r_note_q);
  assign w_boundary   = (r_cnt == (r_period - CNT_W'(1)));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_note_valid) w_next_state = ST_RUN;
      ST_RUN:  if (w_boundary && !w_note_valid) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_note_q <= '0;
      r_oct_q  <= '0;
      r_cnt    <= '0;
      r_period <= '0;
      r_tone   <= 1'b0;
    end else begin
      r_note_q <= note_in;
      r_oct_q  <= octave_in;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (w_note_valid) begin
          r_period <= w_lut_period;
          r_tone   <= 1'b1;
        end else begin
          r_tone   <= 1'b0;
        end
      end else if (w_boundary) begin
        // Pitch is re-sampled only here so every half-period is whole
        r_cnt <= '0;
        if (w_note_valid) begin
          r_tone   <= ~r_tone;
          r_period <= w_lut_period;
        end else begin
          r_tone   <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign playing = (r_state == ST_RUN);

`ifdef TONE_VOLUME_EN
  logic [1:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pwm_cnt <= 2'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 2'd1;
    end
  end

  assign speaker_out = r_tone & (r_pwm_cnt <= volume);
`else
  assign speaker_out = r_tone;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buzzer_tone_gen.sv
// ============================================================================
// Module   : tb_buzzer_tone_gen
// Brief    : Directed bench for buzzer_tone_gen with a countdown pitch model;
//            runs at a scaled-down clock so half-periods stay short.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_buzzer_tone_gen;

  localparam longint unsigned CLK_HZ = 100_000;
  localparam int unsigned     CNT_W  = 20;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] note_in   = 4'd6;
  logic [1:0] octave_in = 2'b00;
`ifdef TONE_VOLUME_EN
  logic [1:0] volume    = 2'd3;
`endif
  logic       speaker_out;
  logic       playing;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  buzzer_tone_gen #(
    .CLK_FREQ_HZ(CLK_HZ),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note_in    (note_in),
    .octave_in  (octave_in),
`ifdef TONE_VOLUME_EN
    .volume     (volume),
`endif
    .speaker_out(speaker_out),
    .playing    (playing)
  );

  // Half-period straight from the pitch formula
  function automatic int hp(input int n, input int o);
    int f;
    int mid;
    case (n)
      1: f = 26163;
      2: f = 29366;
      3: f = 32963;
      4: f = 34923;
      5: f = 39200;
      6: f = 44000;
      7: f = 49388;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    mid = int'((longint'(CLK_HZ) * 64'd50) / longint'(f));
    if (o == 1) return mid / 2;
    if (o == 2) return mid * 2;
    return mid;
  endfunction

  function automatic bit is_note(input int n);
    return (n >= 1) && (n <= 7);
  endfunction

  // Model: note/octave seen one edge late; m_left counts down the current half-period
  int m_nq = 0, m_oq = 0, m_left = 0;
  bit m_play = 0, m_level = 0, m_live = 0;
`ifdef TONE_VOLUME_EN
  bit [1:0] m_pwm = 0;
`endif

  always @(posedge clk) begin
    if (!reset) begin
      m_nq = 0; m_oq = 0; m_play = 0; m_level = 0; m_left = 0;
`ifdef TONE_VOLUME_EN
      m_pwm = 0;
`endif
    end else begin
      if (!m_play) begin
        if (is_note(m_nq)) begin
          m_play = 1; m_level = 1; m_left = hp(m_nq, m_oq);
        end else begin
          m_level = 0;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (is_note(m_nq)) begin
            m_level = !m_level; m_left = hp(m_nq, m_oq);
          end else begin
            m_play = 0; m_level = 0;
          end
        end
      end
      m_nq = int'(note_in);
      m_oq = int'(octave_in);
`ifdef TONE_VOLUME_EN
      m_pwm = m_pwm + 2'd1;
`endif
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      bit exp_spk;
      exp_spk = m_level;
`ifdef TONE_VOLUME_EN
      exp_spk = m_level && (m_pwm <= volume);
`endif
      checks++;
      if (speaker_out !== exp_spk || playing !== m_play) begin
        errors++;
        $display("FAIL model_cmp t=%0t speaker_out=%0b playing=%0b expected %0b/%0b",
                 $time, speaker_out, playing, exp_spk, m_play);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles the chosen output stays at lvl, starting at the current negedge
  task automatic run_len(input bit use_play, input bit lvl, output int n);
    n = 0;
    while (((use_play ? playing : speaker_out) == lvl) && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_for(input bit lvl, input string name);
    int k = 0;
    while (speaker_out != lvl && k < 1000) begin
      k++;
      @(negedge clk);
    end
    check(name, int'(speaker_out), int'(lvl));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n2;
    check("pin_hp_a4_mid", hp(6, 0), 113);
    check("pin_hp_a4_high", hp(6, 1), 56);
    check("pin_hp_c_low", hp(1, 2), 382);

    // 1: reset then A4
    tick(3);
    check("t1_reset_spk", int'(speaker_out), 0);
    check("t1_reset_play", int'(playing), 0);
    reset = 1'b1;
    tick(1);
    check("t1_no_rise_1cyc", int'(speaker_out), 0);
    tick(1);
    check("t1_rise_2cyc", int'(speaker_out), 1);
    check("t1_playing", int'(playing), 1);
    run_len(0, 1, n); check("t1_a4_high", n, 113);
    run_len(0, 0, n); check("t1_a4_low", n, 113);

    // 2: octave switch mid half-period
    tick(40);
    octave_in = 2'b01;
    run_len(0, 1, n); check("t2_current_half", n, 73);
    run_len(0, 0, n); check("t2_high_oct_low", n, 56);
    run_len(0, 1, n); check("t2_high_oct_high", n, 56);

    // 3: low C
    tick(10);
    note_in = 4'd1; octave_in = 2'b10;
    run_len(0, 0, n); check("t3_finish_half", n, 46);
    run_len(0, 1, n); run_len(0, 0, n2);
    check("t3_lowc_high", n, 382);
    check("t3_lowc_period", n + n2, 764);

    // 4a: note-off while high
    note_in = 4'd0;
    run_len(0, 1, n); check("t4_high_persists", n, 382);
    check("t4_off_play", int'(playing), 0);
    tick(5);
    note_in = 4'd9;
    tick(10);
    check("t4_note9_idle", int'(playing), 0);
    check("t4_note9_spk", int'(speaker_out), 0);
    note_in = 4'd0;
    tick(3);

    // 4b: note-off while low
    note_in = 4'd6; octave_in = 2'b00;
    wait_for(1, "t4_restart_rise");
    run_len(0, 1, n); check("t4b_high", n, 113);
    note_in = 4'd0;
    run_len(1, 1, n); check("t4b_play_to_boundary", n, 113);
    check("t4b_spk_low", int'(speaker_out), 0);

    // short rest between boundaries is not seen
    note_in = 4'd6;
    wait_for(1, "t4c_rise");
    tick(20);
    note_in = 4'd0;
    tick(10);
    note_in = 4'd6;
    check("t4c_still_playing", int'(playing), 1);
    run_len(0, 1, n); check("t4c_no_restart", n, 83);

    // 5: reset mid half-period
    tick(30);
    reset = 1'b0;
    tick(1);
    check("t5_reset_spk", int'(speaker_out), 0);
    check("t5_reset_play", int'(playing), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t5_no_rise_1cyc", int'(speaker_out), 0);
    tick(1);
    check("t5_rise", int'(speaker_out), 1);
    run_len(0, 1, n); check("t5_clean_high", n, 113);

`ifdef TONE_VOLUME_EN
    // 6: 50% gating while tone high
    begin
      bit s[8];
      int ones = 0;
      volume = 2'd1;
      tick(115);
      for (int i = 0; i < 8; i++) begin
        s[i] = speaker_out;
        ones += int'(s[i]);
        tick(1);
      end
      check("t6_ones_in_8", ones, 4);
      for (int i = 0; i < 4; i++) check("t6_periodic", int'(s[i]), int'(s[i + 4]));
    end
`endif

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
